// File: rtl/incr_chk_pkg.sv
// Shared types and constants for the incrementing-stream checker.
package incr_chk_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Wide enough for LOCK_CYCLES up to 15.
    localparam int RUN_W = 4;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr wins over inc.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && (value != {W{1'b1}})) begin
            value <= value + W'(1);
        end
    end

endmodule

// File: rtl/incr_stream_checker.sv
// Locks onto a free-running up-counter bus and flags any sample that is not previous+1.
module incr_stream_checker
    import incr_chk_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int LOCK_CYCLES = 4,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_value,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] last_value,
    output logic [WIDTH-1:0] expected
);

    localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_CYCLES);

    state_t           state;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_nxt;
    logic             match;
    logic             err_inc;

    assign match   = (in_value == expected);
    assign run_nxt = run + RUN_W'(1);
    // clear masks the error so a simultaneous mismatch neither pulses nor counts.
    assign err_inc = in_valid && !clear && (state == LOCKED) && !match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            run        <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            last_value <= '0;
            expected   <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (in_valid) begin
                last_value <= in_value;
                expected   <= in_value + WIDTH'(1);
            end
            if (clear) begin
                state  <= IDLE;
                locked <= 1'b0;
                run    <= '0;
            end else if (in_valid) begin
                unique case (state)
                    IDLE: begin
                        state <= ACQUIRE;
                        run   <= '0;
                    end
                    ACQUIRE: begin
                        if (match) begin
                            if (run_nxt == LOCK_RUN) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                                run    <= '0;
                            end else begin
                                run <= run_nxt;
                            end
                        end else begin
                            run <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!match) begin
                            state     <= ACQUIRE;
                            locked    <= 1'b0;
                            run       <= '0;
                            err_pulse <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        locked <= 1'b0;
                        run    <= '0;
                    end
                endcase
            end
        end
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (err_inc),
        .value (err_count)
    );

endmodule

// File: tb/tb_incr_stream_checker.sv
// Directed bench for incr_stream_checker with default parameters.
module tb_incr_stream_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_value;
    logic        clear;
    logic        locked;
    logic        err_pulse;
    logic [7:0]  err_count;
    logic [31:0] last_value;
    logic [31:0] expected;

    int total = 0;
    int fails = 0;
    int exp_err = 0;
    logic [31:0] v;

    always #5 clk = ~clk;

    incr_stream_checker #(.WIDTH(32), .LOCK_CYCLES(4), .ERR_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_value   (in_value),
        .clear      (clear),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_count  (err_count),
        .last_value (last_value),
        .expected   (expected)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs at negedge, return just after the next rising edge.
    task automatic step(input logic vld, input logic [31:0] val, input logic clr);
        @(negedge clk);
        in_valid = vld;
        in_value = val;
        clear    = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic bump_err();
        exp_err = (exp_err == 255) ? 255 : exp_err + 1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_value = '0; clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_pulse", 32'(err_pulse), 32'd0);
        chk("rst_count", 32'(err_count), 32'd0);
        chk("rst_last", last_value, 32'd0);
        chk("rst_expected", expected, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Acquire on 10..14.
        for (int i = 10; i <= 13; i++) step(1'b1, 32'(i), 1'b0);
        chk("acq_not_yet", 32'(locked), 32'd0);
        step(1'b1, 32'd14, 1'b0);
        chk("acq_locked", 32'(locked), 32'd1);
        chk("acq_count", 32'(err_count), 32'd0);
        chk("acq_expected", expected, 32'd15);
        chk("acq_last", last_value, 32'd14);

        // Locked mismatch 21 -> 25, then relock on 26..29.
        for (int i = 15; i <= 21; i++) step(1'b1, 32'(i), 1'b0);
        chk("pre_err_locked", 32'(locked), 32'd1);
        step(1'b1, 32'd25, 1'b0);
        bump_err();
        chk("err_pulse_hi", 32'(err_pulse), 32'd1);
        chk("err_count1", 32'(err_count), 32'd1);
        chk("err_unlock", 32'(locked), 32'd0);
        chk("err_last", last_value, 32'd25);
        chk("err_expected", expected, 32'd26);
        step(1'b0, 32'd0, 1'b0);
        chk("err_pulse_lo", 32'(err_pulse), 32'd0);
        for (int i = 26; i <= 28; i++) step(1'b1, 32'(i), 1'b0);
        chk("relock_not_yet", 32'(locked), 32'd0);
        step(1'b1, 32'd29, 1'b0);
        chk("relock", 32'(locked), 32'd1);

        // Wrap: FFFFFFFA mismatches, lock at FFFFFFFE, then FFFFFFFF, 0, 1.
        step(1'b1, 32'hFFFF_FFFA, 1'b0);
        bump_err();
        chk("wrap_err_count", 32'(err_count), 32'(exp_err));
        for (int i = 0; i < 4; i++) step(1'b1, 32'hFFFF_FFFB + 32'(i), 1'b0);
        chk("wrap_locked", 32'(locked), 32'd1);
        step(1'b1, 32'hFFFF_FFFF, 1'b0);
        step(1'b1, 32'h0, 1'b0);
        chk("wrap_zero_pulse", 32'(err_pulse), 32'd0);
        step(1'b1, 32'h1, 1'b0);
        chk("wrap_still_locked", 32'(locked), 32'd1);
        chk("wrap_count", 32'(err_count), 32'd2);
        chk("wrap_expected", expected, 32'd2);

        // Gaps are ignored: 2, 3, three idle cycles, 4.
        step(1'b1, 32'd2, 1'b0);
        step(1'b1, 32'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'hDEAD_BEEF, 1'b0);
            chk("gap_locked", 32'(locked), 32'd1);
            chk("gap_last", last_value, 32'd3);
            chk("gap_expected", expected, 32'd4);
        end
        step(1'b1, 32'd4, 1'b0);
        chk("gap_after_locked", 32'(locked), 32'd1);
        chk("gap_after_pulse", 32'(err_pulse), 32'd0);
        chk("gap_after_count", 32'(err_count), 32'd2);

        // 300 mismatches with a relock between each; count must stick at 255.
        v = 32'd4;
        for (int k = 0; k < 300; k++) begin
            v = v + 32'd10;
            step(1'b1, v, 1'b0);
            bump_err();
            chk("sat_count", 32'(err_count), 32'(exp_err));
            for (int j = 0; j < 4; j++) begin
                v = v + 32'd1;
                step(1'b1, v, 1'b0);
            end
            chk("sat_relock", 32'(locked), 32'd1);
        end
        chk("sat_final", 32'(err_count), 32'd255);

        // Mismatch coincident with clear: no pulse, count cleared, back to IDLE.
        step(1'b1, v + 32'd50, 1'b1);
        chk("clr_pulse", 32'(err_pulse), 32'd0);
        chk("clr_count", 32'(err_count), 32'd0);
        chk("clr_locked", 32'(locked), 32'd0);
        chk("clr_last", last_value, v + 32'd50);
        for (int i = 500; i <= 503; i++) step(1'b1, 32'(i), 1'b0);
        chk("clr_relock_not_yet", 32'(locked), 32'd0);
        step(1'b1, 32'd504, 1'b0);
        chk("clr_relock", 32'(locked), 32'd1);
        chk("clr_relock_count", 32'(err_count), 32'd0);

        // Async reset between edges while locked.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_locked", 32'(locked), 32'd0);
        chk("async_last", last_value, 32'd0);
        chk("async_expected", expected, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'd7, 1'b0);
        chk("post_rst_pulse", 32'(err_pulse), 32'd0);
        // Mismatch while acquiring: silent, run restarts.
        step(1'b1, 32'd20, 1'b0);
        chk("acq_mis_pulse", 32'(err_pulse), 32'd0);
        chk("acq_mis_count", 32'(err_count), 32'd0);
        for (int i = 21; i <= 23; i++) step(1'b1, 32'(i), 1'b0);
        chk("post_rst_not_yet", 32'(locked), 32'd0);
        step(1'b1, 32'd24, 1'b0);
        chk("post_rst_locked", 32'(locked), 32'd1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
